// File: rtl/aloha_fp_pkg.sv
// Purpose: shared float-format types and helpers for the float-to-fixed decode path.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package aloha_fp_pkg;

  // Default single-precision-like layout with an explicit leading one.
  localparam int FP_MANT_W = 24;
  localparam int FP_EXP_W  = 8;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp_t;

  // All-ones exponent marks Inf/NaN.
  localparam logic [FP_EXP_W-1:0] EXP_SPECIAL = '1;

  // Width of a signed shift amount that can hold every value of
  // exp - bias - (mant_w-1) + frac_bits over the full exponent range.
  function automatic int sh_width(input int mant_w, input int exp_w,
                                  input int bias, input int frac_bits);
    int hi;
    int lo;
    int mag;
    int w;
    hi  = (1 << exp_w) - 1 - bias - (mant_w - 1) + frac_bits;
    lo  = -bias - (mant_w - 1) + frac_bits;
    mag = (hi > -lo) ? hi : -lo;
    w   = 1;
    while ((1 << w) <= mag) w++;
    return w + 1;
  endfunction

endpackage

// File: rtl/fp_round_saturate.sv
// Purpose: round-half-away-from-zero, apply sign, saturate to OUT_WIDTH two's complement.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage decides when the result is captured.
// Ports: mag/rnd = truncated magnitude and last shifted-out bit, sign = 1 for negative,
//        pre_ovf = magnitude already known to exceed OUT_WIDTH bits (or Inf/NaN),
//        data/ovf = saturated signed result and saturation flag.
module fp_round_saturate
  import aloha_fp_pkg::*;
#(
  parameter int OUT_WIDTH = 64
) (
  input  logic [OUT_WIDTH-1:0] mag,
  input  logic                 rnd,
  input  logic                 sign,
  input  logic                 pre_ovf,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 ovf
);

  logic [OUT_WIDTH:0] sum;

  always_comb begin
    sum  = {1'b0, mag} + {{OUT_WIDTH{1'b0}}, rnd};
    data = '0;
    ovf  = 1'b0;
    if (!sign) begin
      // Largest positive is 2^(W-1)-1, so bit W-1 or above set means overflow.
      ovf  = pre_ovf | sum[OUT_WIDTH] | sum[OUT_WIDTH-1];
      data = ovf ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : sum[OUT_WIDTH-1:0];
    end else begin
      // Exactly 2^(W-1) is the most negative value and still representable.
      ovf  = pre_ovf | sum[OUT_WIDTH] | (sum[OUT_WIDTH-1] & (|sum[OUT_WIDTH-2:0]));
      data = ovf ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : (~sum[OUT_WIDTH-1:0] + 1'b1);
    end
  end

endmodule

// File: rtl/fp_to_fixed.sv
// Purpose: pipelined sign/exponent/mantissa to rounded, saturated signed integer.
// Latency: 3 cycles accept-to-out_valid; 1 beat per cycle sustained.
// Backpressure: per-stage valid bits, bubbles collapse; in_ready low only when all stages full and out_ready low.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + in_sign/in_exp/in_mant;
//        out_valid/out_ready + out_data (signed) / out_ovf (saturated).
module fp_to_fixed
  import aloha_fp_pkg::*;
#(
  parameter int MANT_WIDTH = 24,
  parameter int EXP_WIDTH  = 8,
  parameter int BIAS       = 127,
  parameter int FRAC_BITS  = 0,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  input  logic [MANT_WIDTH-1:0] in_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_ovf
);

  localparam int SH_W   = sh_width(MANT_WIDTH, EXP_WIDTH, BIAS, FRAC_BITS);
  localparam int SH_OFS = BIAS + MANT_WIDTH - 1 - FRAC_BITS;
  localparam int WIDE_W = OUT_WIDTH + MANT_WIDTH;
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

  typedef struct packed {
    logic                   sign;
    logic                   zero;
    logic                   special;
    logic signed [SH_W-1:0] sh;
    logic [MANT_WIDTH-1:0]  mant;
  } s1_t;

  typedef struct packed {
    logic                 sign;
    logic [OUT_WIDTH-1:0] mag;
    logic                 rnd;
    logic                 pre_ovf;
  } s2_t;

  logic s1_vld, s2_vld, s3_vld;
  logic s1_en, s2_en, s3_en;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  logic [OUT_WIDTH-1:0] rs_dat;
  logic                 rs_ovf;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s3_en     = !s3_vld || out_ready;
  assign s2_en     = !s2_vld || s3_en;
  assign s1_en     = !s1_vld || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s3_vld;

  // ---------------- S1: classify exponent, compute signed shift ----------------
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = in_sign;
    s1_d.zero    = (in_exp == '0);
    s1_d.special = (in_exp == EXP_ONES);
    // Modular SH_W-bit arithmetic; the result always fits by construction of SH_W.
    s1_d.sh      = signed'(SH_W'({1'b0, in_exp}) - SH_W'(SH_OFS));
    s1_d.mant    = in_mant;
  end

  // ---------------- S2: shift into magnitude, capture round bit ----------------
  logic [WIDE_W-1:0]   lsh_wide;
  logic [MANT_WIDTH:0] rsh_wide;
  logic [SH_W-1:0]     sh_abs;

  always_comb begin
    s2_d      = '0;
    lsh_wide  = '0;
    rsh_wide  = '0;
    sh_abs    = '0;
    s2_d.sign = s1_q.sign;
    if (s1_q.zero) begin
      // flushed: magnitude 0, no overflow
    end else if (s1_q.special) begin
      s2_d.pre_ovf = 1'b1;
    end else if (!s1_q.sh[SH_W-1]) begin
      sh_abs = s1_q.sh;
      if (int'(sh_abs) >= OUT_WIDTH) begin
        // Every mantissa bit lands at or above OUT_WIDTH.
        s2_d.pre_ovf = |s1_q.mant;
      end else begin
        lsh_wide     = WIDE_W'(s1_q.mant) << sh_abs;
        s2_d.mag     = lsh_wide[OUT_WIDTH-1:0];
        s2_d.pre_ovf = |lsh_wide[WIDE_W-1:OUT_WIDTH];
      end
    end else begin
      // Appending a zero below the LSB makes bit 0 the last bit shifted out;
      // shifts past the mantissa width naturally give magnitude 0, round 0.
      sh_abs   = -s1_q.sh;
      rsh_wide = {s1_q.mant, 1'b0} >> sh_abs;
      s2_d.mag = OUT_WIDTH'(rsh_wide[MANT_WIDTH:1]);
      s2_d.rnd = rsh_wide[0];
    end
  end

  // ---------------- S3: round, sign, saturate ----------------
  fp_round_saturate #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_round_sat (
    .mag     (s2_q.mag),
    .rnd     (s2_q.rnd),
    .sign    (s2_q.sign),
    .pre_ovf (s2_q.pre_ovf),
    .data    (rs_dat),
    .ovf     (rs_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s3_vld   <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_vld <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_en) begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_q <= s2_d;
      end
      if (s3_en) begin
        s3_vld <= s2_vld;
        if (s2_vld) begin
          out_data <= rs_dat;
          out_ovf  <= rs_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Purpose: scoreboard bench for fp_to_fixed with directed and randomized beats.
// Latency: expects 3 cycles accept-to-output whenever out_ready is held high.
// Backpressure: out_ready held high, low, or randomized per phase.
module tb_fp_to_fixed;
  import aloha_fp_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_ovf;

  fp_to_fixed #(
    .MANT_WIDTH(24), .EXP_WIDTH(8), .BIAS(127), .FRAC_BITS(0), .OUT_WIDTH(64)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  typedef struct {
    logic [63:0] data;
    logic        ovf;
    int          acc_cyc;
    bit          lat_chk;
  } sb_t;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [63:0] d;
    logic        o;
  } vec_t;

  localparam logic [63:0] POS_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG_MIN = 64'h8000_0000_0000_0000;

  vec_t vecs [17] = '{
    '{1'b0, 8'd127, 24'h800000, 64'd1,                   1'b0},
    '{1'b0, 8'd128, 24'hE00000, 64'd4,                   1'b0},
    '{1'b1, 8'd128, 24'hA00000, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0},
    '{1'b0, 8'd125, 24'hCCCCCD, 64'd0,                   1'b0},
    '{1'b0, 8'd126, 24'h800000, 64'd1,                   1'b0},
    '{1'b0, 8'd0,   24'h123456, 64'd0,                   1'b0},
    '{1'b1, 8'd0,   24'hABCDEF, 64'd0,                   1'b0},
    '{1'b0, 8'd190, 24'h800000, POS_MAX,                 1'b1},
    '{1'b1, 8'd190, 24'h800000, NEG_MIN,                 1'b0},
    '{1'b0, 8'd255, 24'h000000, POS_MAX,                 1'b1},
    '{1'b1, 8'd255, 24'h400000, NEG_MIN,                 1'b1},
    '{1'b1, 8'd191, 24'h800000, NEG_MIN,                 1'b1},
    '{1'b1, 8'd126, 24'h800000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0},
    '{1'b1, 8'd100, 24'h000001, 64'd0,                   1'b0},
    '{1'b0, 8'd150, 24'hFFFFFF, 64'd16777215,            1'b0},
    '{1'b0, 8'd189, 24'hFFFFFF, 64'h7FFF_FF80_0000_0000, 1'b0},
    '{1'b0, 8'd190, 24'hFFFFFF, POS_MAX,                 1'b1}
  };

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  int  rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random
  bit  chk_rdy  = 0;
  bit  hold_vld = 0;
  logic [63:0] hold_dat;
  logic        hold_ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact value mant*2^(exp-150) with 128-bit arithmetic,
  // round half away from zero as floor((|x| + 1/2)), then saturate.
  function automatic sb_t model(input logic s, input logic [7:0] e, input logic [23:0] m);
    sb_t r;
    int sh;
    logic [127:0] mag;
    r.data = '0; r.ovf = 1'b0; r.acc_cyc = 0; r.lat_chk = 0;
    if (e == 8'd0) return r;
    if (e == EXP_SPECIAL) begin
      r.data = s ? NEG_MIN : POS_MAX;
      r.ovf  = 1'b1;
      return r;
    end
    sh = int'(e) - 150;
    if (sh >= 0)       mag = 128'(m) << ((sh > 100) ? 100 : sh);
    else if (-sh > 40) mag = '0;
    else               mag = (128'(m) + (128'd1 << (-sh - 1))) >> (-sh);
    if (!s && mag > 128'(POS_MAX)) begin
      r.data = POS_MAX; r.ovf = 1'b1;
    end else if (s && mag > 128'(NEG_MIN)) begin
      r.data = NEG_MIN; r.ovf = 1'b1;
    end else begin
      r.data = s ? (~mag[63:0] + 64'd1) : mag[63:0];
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                      input logic [63:0] d, input logic o);
    sb_t ent;
    bit  taken = 0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ent.data = d; ent.ovf = o; ent.acc_cyc = cyc; ent.lat_chk = (rdy_mode == 1);
        sb.push_back(ent);
        taken = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!taken) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic s; logic [7:0] e; logic [23:0] m; sb_t r;
    int pick;
    s    = 1'($urandom_range(0, 1));
    pick = $urandom_range(0, 9);
    e    = (pick == 0) ? 8'd0 : (pick == 1) ? 8'd255 : 8'($urandom_range(100, 195));
    m    = 24'($urandom());
    r    = model(s, e, m);
    send(s, e, m, r.data, r.ovf);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500; t++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_vld = 0;
      end else begin
        if (hold_vld && out_valid) begin
          check("stall_hold_data", out_data, hold_dat);
          check("stall_hold_ovf", 64'(out_ovf), 64'(hold_ovf));
        end
        hold_vld = out_valid && !out_ready;
        hold_dat = out_data;
        hold_ovf = out_ovf;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_ovf", 64'(out_ovf), 64'(e.ovf));
            if (e.lat_chk) check("latency", 64'(cyc - e.acc_cyc), 64'd3);
          end
        end
      end
    end
  end

  // in_ready must drop only when three beats are in flight and out_ready is low.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (chk_rdy && !rst) check("in_ready", 64'(in_ready), 64'((sb.size() < 3) || out_ready));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    chk_rdy = 1;

    // Directed values with out_ready held high.
    foreach (vecs[i]) send(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].d, vecs[i].o);
    wait_drain();

    // Throughput: 20 back-to-back beats.
    for (int i = 0; i < 20; i++) send_rand();
    wait_drain();

    // Backpressure: 10 beats under random out_ready, then soak with gaps.
    rdy_mode = 2;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send_rand();
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_rand();
    end
    rdy_mode = 1;
    wait_drain();

    // Reset with three beats in flight.
    rdy_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) send_rand();
    chk_rdy = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_out_ovf", 64'(out_ovf), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk_rdy = 1;
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("post_rst_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(1'b0, 8'd127, 24'h800000, 64'd1, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
